nocr_type_router: RTL

Parametrised successor to the single-register NoC receive datapath. It accepts packets over a valid/ready handshake and decodes their destination and type fields. Each valid packet is queued in one of four per-type FIFOs, and a round-robin arbiter drains the FIFOs onto a single output stream. Invalid packets and packets for disabled destinations are dropped and counted.

---
 rtl/nocr_pkg.sv | 22 ++
 rtl/nocr_fifo.sv | 47 ++++
 rtl/nocr_type_router.sv | 117 +++++++++++
 3 files changed

// File: rtl/nocr_pkg.sv
// Shared types and constants for the NoC type router.
// Packet type encoding, type-FIFO count and drop counter width.
package nocr_pkg;

    typedef enum logic [1:0] {
        DATA     = 2'b00,
        CONTROL  = 2'b01,
        RESPONSE = 2'b10,
        RESERVE  = 2'b11
    } pkt_type_e;

    localparam int NUM_TYPES  = 4;
    localparam int DROP_CNT_W = 8;

    function automatic logic [1:0] rr_idx(
        input logic [1:0] base,
        input int unsigned off
    );
        return base + off[1:0];
    endfunction

endpackage

// File: rtl/nocr_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered storage array.
// Pushes are ignored when full and pops are ignored when empty.
module nocr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count   = wr_q - rd_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: empty masks the head at the top level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/nocr_type_router.sv
// NoC receive router: decodes packets into per-type FIFOs and drains
// them onto one output stream with a round-robin arbiter.
module nocr_type_router
    import nocr_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NUM_DEST   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int DEST_W     = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1,
    localparam int PKT_W      = 1 + DATA_W + 2 + DEST_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PKT_W-1:0]      in_packet,
    input  logic [NUM_DEST-1:0]   dest_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_type,
    output logic [DEST_W-1:0]     out_dest,
    output logic [NUM_TYPES-1:0]  fifo_full,
    output logic [NUM_TYPES-1:0]  fifo_empty,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    input  logic                  drop_clr
);
    localparam int ENT_W = DATA_W + DEST_W;

    logic                  vld;
    logic [DATA_W-1:0]     payload;
    pkt_type_e             ptype;
    logic [DEST_W-1:0]     dest;
    logic                  dest_ok;
    logic                  drop;
    logic                  accept;
    logic [NUM_TYPES-1:0]  push;
    logic [NUM_TYPES-1:0]  pop;
    logic [ENT_W-1:0]      head [NUM_TYPES];
    logic [1:0]            grant;
    logic                  found;
    logic                  hs;
    logic [1:0]            rr_ptr_q;
    logic [1:0]            rr_ptr_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    assign vld     = in_packet[PKT_W-1];
    assign payload = in_packet[PKT_W-2 -: DATA_W];
    assign ptype   = pkt_type_e'(in_packet[DEST_W+1:DEST_W]);
    assign dest    = in_packet[DEST_W-1:0];

    // Range test first so a non-power-of-two NUM_DEST never indexes past dest_en.
    assign dest_ok  = (32'(dest) < NUM_DEST) && dest_en[dest];
    assign drop     = !vld || !dest_ok;
    assign in_ready = drop || !fifo_full[ptype];
    assign accept   = in_valid && in_ready;

    for (genvar t = 0; t < NUM_TYPES; t++) begin : g_fifo
        assign push[t] = accept && !drop && (ptype == pkt_type_e'(t));
        assign pop[t]  = hs && (grant == 2'(t));

        nocr_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[t]),
            .pop   (pop[t]),
            .din   ({payload, dest}),
            .full  (fifo_full[t]),
            .empty (fifo_empty[t]),
            .head  (head[t])
        );
    end

    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (!found && !fifo_empty[rr_idx(rr_ptr_q, i)]) begin
                grant = rr_idx(rr_ptr_q, i);
                found = 1'b1;
            end
        end
    end

    assign out_valid = found;
    assign hs        = out_valid && out_ready;
    assign out_data  = out_valid ? head[grant][ENT_W-1:DEST_W] : '0;
    assign out_dest  = out_valid ? head[grant][DEST_W-1:0] : '0;
    assign out_type  = out_valid ? grant : 2'b00;
    assign rr_ptr_d  = hs ? grant + 2'd1 : rr_ptr_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr) begin
            drop_cnt_d = '0;
        end else if (accept && drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule
